// File: rtl/column_sweep_scheduler_if.sv
// Control/status bundle between the column_sweep_scheduler and its
// controller: run/config in, column flags and snapshot ack in, status out.
interface column_sweep_scheduler_if #(
  parameter int NUM_COLS   = 32,
  parameter int ROW_BITS   = 8,
  parameter int SWEEP_BITS = 16
) ();
  logic                  run;
  logic [ROW_BITS-1:0]   height;
  logic [SWEEP_BITS-1:0] max_sweeps;
  logic [SWEEP_BITS-1:0] snap_every;
  logic [NUM_COLS-1:0]   col_flags;
  logic                  snap_ack;
  logic                  start;
  logic                  snap_req;
  logic [ROW_BITS-1:0]   row_idx;
  logic [SWEEP_BITS-1:0] sweep_count;
  logic                  busy;
  logic                  done;

  modport master (
    output run, height, max_sweeps, snap_every,
    output col_flags, snap_ack,
    input  start, snap_req, row_idx, sweep_count,
    input  busy, done
  );

  modport slave (
    input  run, height, max_sweeps, snap_every,
    input  col_flags, snap_ack,
    output start, snap_req, row_idx, sweep_count,
    output busy, done
  );
endinterface

// File: rtl/column_sweep_scheduler.sv
// Lock-step start scheduler for the build_column array: waits for all
// column flags, pulses a common start, counts rows/sweeps, pauses for snapshots.
module column_sweep_scheduler #(
  parameter int NUM_COLS   = 32,
  parameter int ROW_BITS   = 8,
  parameter int SWEEP_BITS = 16
) (
  input logic clk,
  input logic reset,
  column_sweep_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ALL,
    PULSE,
    WAIT_LOW,
    SNAP,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [ROW_BITS-1:0]   row;
  logic [ROW_BITS-1:0]   row_n;
  logic [ROW_BITS-1:0]   height_l;
  logic [ROW_BITS-1:0]   height_n;
  logic [SWEEP_BITS-1:0] sweeps;
  logic [SWEEP_BITS-1:0] sweeps_n;
  logic [SWEEP_BITS-1:0] snap_cnt;
  logic [SWEEP_BITS-1:0] snap_n;
  logic                  run_q;

  logic                  all_set;
  logic                  none_set;
  logic                  sweep_end;
  logic                  launch;
  logic [SWEEP_BITS-1:0] sweep_inc;
  logic [SWEEP_BITS-1:0] snap_inc;
  logic                  max_hit;
  logic                  snap_hit;

  assign all_set   = &bus.col_flags;
  assign none_set  = ~|bus.col_flags;
  assign sweep_end = row == height_l;
  assign sweep_inc = &sweeps ? sweeps
                   : sweeps + SWEEP_BITS'(1);
  assign snap_inc  = snap_cnt + SWEEP_BITS'(1);
  assign max_hit   = |bus.max_sweeps
                   && sweep_inc == bus.max_sweeps;
  assign snap_hit  = |bus.snap_every
                   && snap_inc == bus.snap_every;

  // DONE only re-arms on a fresh rising edge of run
  assign launch = (state == IDLE && bus.run)
               || (state == DONE && bus.run && !run_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      row      <= '0;
      height_l <= '0;
      sweeps   <= '0;
      snap_cnt <= '0;
      run_q    <= 1'b0;
    end else begin
      state    <= state_n;
      row      <= row_n;
      height_l <= height_n;
      sweeps   <= sweeps_n;
      snap_cnt <= snap_n;
      run_q    <= bus.run;
    end
  end

  always_comb begin
    state_n  = state;
    row_n    = row;
    height_n = height_l;
    sweeps_n = sweeps;
    snap_n   = snap_cnt;
    unique case (state)
      IDLE, DONE: begin
        if (launch) begin
          height_n = bus.height;
          row_n    = '0;
          sweeps_n = '0;
          snap_n   = '0;
          state_n  = WAIT_ALL;
        end
      end
      WAIT_ALL: begin
        if (all_set) begin
          if (!sweep_end) begin
            row_n   = row + ROW_BITS'(1);
            state_n = PULSE;
          end else begin
            row_n    = '0;
            sweeps_n = sweep_inc;
            snap_n   = snap_inc;
            if (max_hit || !bus.run) begin
              state_n = DONE;
            end else if (snap_hit) begin
              snap_n  = '0;
              state_n = SNAP;
            end else begin
              state_n = PULSE;
            end
          end
        end
      end
      PULSE: state_n = WAIT_LOW;
      // flags from the last row are still high until the columns see start
      WAIT_LOW: begin
        if (none_set) state_n = WAIT_ALL;
      end
      SNAP: begin
        if (bus.snap_ack) state_n = PULSE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.start       = state == PULSE;
  assign bus.snap_req    = state == SNAP;
  assign bus.busy        = state != IDLE && state != DONE;
  assign bus.done        = state == DONE;
  assign bus.row_idx     = row;
  assign bus.sweep_count = sweeps;

endmodule

// File: tb/tb_column_sweep_scheduler.sv
// Randomized closed-loop bench: column and VGA-writer models drive the
// scheduler; a sweep-level reference model predicts every output each cycle.
module tb_column_sweep_scheduler;

  localparam int NC = 4;
  localparam int RB = 4;
  localparam int SB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  column_sweep_scheduler_if #(
    .NUM_COLS(NC), .ROW_BITS(RB), .SWEEP_BITS(SB)
  ) bus ();

  column_sweep_scheduler #(
    .NUM_COLS(NC), .ROW_BITS(RB), .SWEEP_BITS(SB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // stimulus state
  logic          run_v;
  logic [RB-1:0] h_v;
  logic [SB-1:0] max_v;
  logic [SB-1:0] every_v;
  logic          ack_v;
  logic [NC-1:0] cf;
  logic [NC-1:0] stuck;
  int            cnt [NC];
  int            ack_delay;
  int            ack_wait;
  bit            spur;
  logic          s_prev;
  int            pulses;
  int            snaps;
  logic          snap_prev;
  int            cur_len;
  int            last_len;

  // reference model
  bit            m_go, m_fin, m_low, m_pulse;
  bit            m_pause, m_runq;
  logic [RB-1:0] m_row, m_h;
  logic [SB-1:0] m_sw, m_snap;

  task automatic drive();
    bus.run        = run_v;
    bus.height     = h_v;
    bus.max_sweeps = max_v;
    bus.snap_every = every_v;
    bus.col_flags  = cf & ~stuck;
    bus.snap_ack   = ack_v;
  endtask

  task automatic model_reset();
    m_go = 0; m_fin = 0; m_low = 0;
    m_pulse = 0; m_pause = 0; m_runq = 0;
    m_row = '0; m_h = '0; m_sw = '0; m_snap = '0;
  endtask

  task automatic finish_run();
    m_go = 0;
    m_fin = 1;
  endtask

  task automatic model_edge();
    logic [NC-1:0] fl;
    bit launch;
    fl = cf & ~stuck;
    launch = (!m_go && !m_fin && run_v)
          || (m_fin && run_v && !m_runq);
    if (launch) begin
      m_go = 1; m_fin = 0;
      m_row = '0; m_sw = '0; m_snap = '0;
      m_h = h_v;
    end else if (m_pulse) begin
      m_pulse = 0;
      m_low = 1;
    end else if (m_low) begin
      if (fl == '0) m_low = 0;
    end else if (m_pause) begin
      if (ack_v) begin
        m_pause = 0;
        m_pulse = 1;
      end
    end else if (m_go && &fl) begin
      if (m_row != m_h) begin
        m_row = m_row + RB'(1);
        m_pulse = 1;
      end else begin
        m_row = '0;
        if (m_sw != '1) m_sw = m_sw + SB'(1);
        m_snap = m_snap + SB'(1);
        if (max_v != 0 && m_sw == max_v) finish_run();
        else if (!run_v) finish_run();
        else if (every_v != 0 && m_snap == every_v) begin
          m_pause = 1;
          m_snap = '0;
        end else m_pulse = 1;
      end
    end
    m_runq = run_v;
  endtask

  function automatic logic [31:0] obs();
    return 32'({bus.start, bus.snap_req, bus.busy,
                bus.done, bus.row_idx, bus.sweep_count});
  endfunction

  function automatic logic [31:0] expv();
    return 32'({m_pulse, m_pause, m_go, m_fin, m_row, m_sw});
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("cycle", obs(), expv());
    if (bus.start) pulses++;
    if (bus.snap_req && !snap_prev) snaps++;
    snap_prev = bus.snap_req;
    if (bus.snap_req) cur_len++;
    else if (cur_len > 0) begin
      last_len = cur_len;
      cur_len = 0;
    end
    // columns clear on the edge that sees start, then finish a node later
    for (int i = 0; i < NC; i++) begin
      if (s_prev) begin
        cf[i] = 1'b0;
        cnt[i] = int'($urandom_range(5, 1));
      end else if (!cf[i] && cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) cf[i] = 1'b1;
      end
    end
    s_prev = bus.start;
    if (bus.snap_req) begin
      ack_wait++;
      ack_v = ack_wait > ack_delay;
    end else begin
      ack_wait = 0;
      ack_v = spur && ($urandom_range(7, 0) == 0);
    end
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    run_v = 0; h_v = '0; max_v = '0; every_v = '0;
    ack_v = 0; stuck = '0; cf = '0;
    ack_delay = 2; ack_wait = 0; spur = 0;
    s_prev = 0; pulses = 0; snaps = 0; snap_prev = 0;
    cur_len = 0; last_len = 0;
    for (int i = 0; i < NC; i++)
      cnt[i] = int'($urandom_range(10, 2));
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("reset", obs(), 32'(0));
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_until_done(int limit);
    for (int i = 0; i < limit && !m_fin; i++) step();
    check("finish", 32'(bus.done), 32'(1));
  endtask

  initial begin
    // T1: staggered self-init flags, latency of the first start
    begin
      int t_last, t_start;
      t_last = -1; t_start = -1;
      do_reset();
      h_v = 4'd3; run_v = 1;
      cnt[0] = 5; cnt[1] = 7; cnt[2] = 9; cnt[3] = 12;
      drive();
      for (int t = 1; t <= 40 && t_start < 0; t++) begin
        step();
        if (&cf && t_last < 0) t_last = t;
        if (bus.start && t_start < 0) t_start = t;
      end
      check("t1_last_flag", 32'(t_last), 32'(12));
      check("t1_col_sees_start", 32'(t_start + 1),
            32'(t_last + 2));
      check("t1_row", 32'(bus.row_idx), 32'(1));
    end

    // T2: one column never finishes
    begin
      int p0;
      do_reset();
      h_v = 4'd3; run_v = 1; stuck = 4'b0001;
      drive();
      p0 = pulses;
      repeat (100) step();
      check("t2_pulses", 32'(pulses - p0), 32'(0));
      check("t2_busy", 32'(bus.busy), 32'(1));
      check("t2_row", 32'(bus.row_idx), 32'(0));
    end

    // T3: sweep limit, then DONE hold and re-launch on run edge
    do_reset();
    h_v = 4'd3; max_v = 4'd2; run_v = 1;
    drive();
    run_until_done(500);
    check("t3_pulses", 32'(pulses),
          32'(int'(max_v) * (int'(h_v) + 1) - 1));
    check("t3_sweeps", 32'(bus.sweep_count), 32'(2));
    repeat (5) step();
    check("t3_hold", 32'(bus.done), 32'(1));
    run_v = 0; drive(); step();
    run_v = 1; drive(); step();
    check("t3_relaunch", 32'(bus.busy), 32'(1));
    run_until_done(500);
    check("t3_sweeps2", 32'(bus.sweep_count), 32'(2));

    // T4: snapshot every sweep with slow ack; last sweep skips snap
    do_reset();
    h_v = 4'd1; max_v = 4'd3; every_v = 4'd1;
    ack_delay = 20; run_v = 1;
    drive();
    run_until_done(800);
    check("t4_snaps", 32'(snaps), 32'(2));
    check("t4_snap_len", 32'(last_len), 32'(21));
    check("t4_pulses", 32'(pulses), 32'(5));

    // T5: run dropped at row 1 of sweep 3
    begin
      int k;
      k = 0;
      do_reset();
      h_v = 4'd3; run_v = 1;
      drive();
      while (!(m_sw == 2 && m_row == 1) && k < 1000) begin
        step();
        k++;
      end
      check("t5_reach", 32'(k < 1000), 32'(1));
      run_v = 0; drive();
      run_until_done(500);
      check("t5_sweeps", 32'(bus.sweep_count), 32'(3));
      check("t5_row", 32'(bus.row_idx), 32'(0));
    end

    // T6: async reset while waiting for flags to drop
    begin
      int k;
      k = 0;
      do_reset();
      h_v = 4'd2; run_v = 1;
      drive();
      while (!(m_low && m_sw != 0 && m_row != 0)
             && k < 1000) begin
        step();
        k++;
      end
      check("t6_reach", 32'(k < 1000), 32'(1));
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("t6_start", 32'(bus.start), 32'(0));
      check("t6_busy", 32'(bus.busy), 32'(0));
      check("t6_row", 32'(bus.row_idx), 32'(0));
      check("t6_sweeps", 32'(bus.sweep_count), 32'(0));
    end

    // T7: sweep counter saturation
    begin
      int k;
      k = 0;
      do_reset();
      run_v = 1;
      drive();
      while (m_sw != '1 && k < 3000) begin
        step();
        k++;
      end
      check("t7_reach", 32'(k < 3000), 32'(1));
      repeat (40) step();
      run_v = 0; drive();
      run_until_done(200);
      check("t7_sat", 32'(bus.sweep_count), 32'(15));
    end

    // randomized runs: config, late height changes, stray acks
    for (int r = 0; r < 8; r++) begin
      int drop;
      do_reset();
      h_v = RB'($urandom_range(4, 0));
      max_v = SB'($urandom_range(5, 0));
      every_v = SB'($urandom_range(3, 0));
      ack_delay = int'($urandom_range(6, 0));
      spur = 1;
      drop = int'($urandom_range(250, 20));
      run_v = 1;
      drive();
      for (int i = 0; i < 3000 && !m_fin; i++) begin
        if ($urandom_range(15, 0) == 0)
          h_v = RB'($urandom_range(4, 0));
        if (i == drop) run_v = 0;
        drive();
        step();
      end
      check("rand_done", 32'(bus.done), 32'(1));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
